// File: rtl/csr_unit.sv
// Zicsr execution unit: tohost/mscratch registers, registered old-value read and illegal-access flag.
// Optional 64-bit cycle/instret counters are built only when CSR_COUNTERS_EN is defined.
module csr_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            csr_we,
  input  logic            csr_rd,
  input  logic [2:0]      funct3,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      zimm,
  input  logic            inst_retire,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic [XLEN-1:0] tohost
);

  localparam logic [11:0] ADDR_TOHOST   = 12'h51E;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            active;
  logic            do_write;
  logic            known;
  logic            read_only;
  logic            illegal_now;
  logic            commit;

`ifdef CSR_COUNTERS_EN
  localparam logic [2*XLEN-1:0] CNT_ONE = {{(2*XLEN-1){1'b0}}, 1'b1};
  logic [2*XLEN-1:0] cycle_cnt;
  logic [2*XLEN-1:0] instret_cnt;
`else
  logic unused_retire;
  assign unused_retire = inst_retire;
`endif

  // funct3 000/100 are no-ops: no write, no capture, no flag
  assign active = csr_we && !stall && (funct3[1:0] != 2'b00);
  assign src    = funct3[2] ? {{(XLEN-5){1'b0}}, zimm} : rs1_data;
  // set/clear with a zero source register index never write, so RO CSRs stay readable
  assign do_write = (funct3[1:0] == 2'b01) || (zimm != 5'd0);

  always_comb begin
    old_val   = '0;
    known     = 1'b1;
    read_only = 1'b0;
    case (csr_addr)
      ADDR_TOHOST:   old_val = tohost;
      ADDR_MSCRATCH: old_val = mscratch;
`ifdef CSR_COUNTERS_EN
      ADDR_CYCLE:    begin old_val = cycle_cnt[XLEN-1:0];      read_only = 1'b1; end
      ADDR_CYCLEH:   begin old_val = cycle_cnt[2*XLEN-1:XLEN]; read_only = 1'b1; end
      ADDR_INSTRET:  begin old_val = instret_cnt[XLEN-1:0];    read_only = 1'b1; end
      ADDR_INSTRETH: begin old_val = instret_cnt[2*XLEN-1:XLEN]; read_only = 1'b1; end
`endif
      default:       known = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      default: new_val = old_val & ~src;
    endcase
  end

  assign illegal_now = active && (!known || (read_only && do_write));
  assign commit      = active && do_write && !illegal_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tohost      <= '0;
      mscratch    <= '0;
      csr_rdata   <= '0;
      csr_illegal <= 1'b0;
    end else begin
      csr_illegal <= illegal_now;
      if (active && csr_rd)
        csr_rdata <= old_val;
      if (commit && csr_addr == ADDR_TOHOST)
        tohost <= new_val;
      if (commit && csr_addr == ADDR_MSCRATCH)
        mscratch <= new_val;
    end
  end

`ifdef CSR_COUNTERS_EN
  // cycle runs through stalls; instret only counts unstalled retirements
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      if (inst_retire && !stall)
        instret_cnt <= instret_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios plus randomized traffic against a reference model.
// Builds with or without CSR_COUNTERS_EN; the model follows the same macro.
module tb_csr_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        csr_we;
  logic        csr_rd;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic        inst_retire;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] tohost;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_tohost, m_mscratch, m_rdata;
  logic        m_ill;
  logic [63:0] m_cycle, m_instret;

  csr_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .csr_we(csr_we), .csr_rd(csr_rd),
    .funct3(funct3), .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm),
    .inst_retire(inst_retire), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .tohost(tohost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tohost = 0; m_mscratch = 0; m_rdata = 0; m_ill = 0;
    m_cycle = 0; m_instret = 0;
  endtask

  // One clock: predict from pre-edge state, advance, then compare the outputs.
  task automatic step();
    logic        act, known, ro, wr, ill;
    logic [31:0] src, old, nv;
    act   = csr_we && !stall && (funct3 != 3'b000) && (funct3 != 3'b100);
    src   = funct3[2] ? {27'b0, zimm} : rs1_data;
    known = 1'b1; ro = 1'b0; old = 32'h0;
    case (csr_addr)
      12'h51E: old = m_tohost;
      12'h340: old = m_mscratch;
`ifdef CSR_COUNTERS_EN
      12'hC00: begin old = m_cycle[31:0];    ro = 1'b1; end
      12'hC80: begin old = m_cycle[63:32];   ro = 1'b1; end
      12'hC02: begin old = m_instret[31:0];  ro = 1'b1; end
      12'hC82: begin old = m_instret[63:32]; ro = 1'b1; end
`endif
      default: known = 1'b0;
    endcase
    wr = (funct3 == 3'b001) || (funct3 == 3'b101) || (zimm != 5'd0);
    if (funct3 == 3'b001 || funct3 == 3'b101)      nv = src;
    else if (funct3 == 3'b010 || funct3 == 3'b110) nv = old | src;
    else                                           nv = old & ~src;
    ill = act && (!known || (ro && wr));
    @(posedge clk);
    #1;
    m_cycle = m_cycle + 64'd1;
    if (inst_retire && !stall) m_instret = m_instret + 64'd1;
    if (act && wr && !ill && csr_addr == 12'h51E) m_tohost = nv;
    if (act && wr && !ill && csr_addr == 12'h340) m_mscratch = nv;
    if (act && csr_rd) m_rdata = old;
    m_ill = ill;
    chk("tohost", tohost, m_tohost);
    chk("rdata", csr_rdata, m_rdata);
    chk("illegal", {31'b0, csr_illegal}, {31'b0, m_ill});
  endtask

  task automatic idle();
    csr_we = 0; csr_rd = 0; funct3 = 0; csr_addr = 0; rs1_data = 0; zimm = 0;
    stall = 0; inst_retire = 0;
  endtask

  task automatic op(input logic rd, input logic [2:0] f3, input logic [11:0] addr,
                    input logic [31:0] rs1, input logic [4:0] zi);
    csr_we = 1; csr_rd = rd; funct3 = f3; csr_addr = addr; rs1_data = rs1; zimm = zi;
    step();
    idle();
  endtask

  initial begin
    logic [11:0] addrs [8];
    addrs = '{12'h51E, 12'h340, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h000};
    idle();
    rst_n = 0;
    model_reset();
    #12;
    rst_n = 1;
    chk("reset_tohost", tohost, 32'h0);
    chk("reset_rdata", csr_rdata, 32'h0);

    // RW / RS / RCI on tohost
    op(1, 3'b001, 12'h51E, 32'h1234, 5'd1);
    chk("csrrw_tohost", tohost, 32'h1234);
    op(1, 3'b010, 12'h51E, 32'h0F00, 5'd2);
    chk("csrrs_rdata", csr_rdata, 32'h1234);
    chk("csrrs_tohost", tohost, 32'h1F34);
    op(0, 3'b111, 12'h51E, 32'h0, 5'd4);
    chk("csrrci_tohost", tohost, 32'h1F30);

    // csr_rd low: mscratch written, rdata held, then read back
    op(0, 3'b001, 12'h340, 32'hA5, 5'd3);
    chk("rd0_rdata_held", csr_rdata, 32'h1234);
    op(1, 3'b010, 12'h340, 32'h0, 5'd0);
    chk("mscratch_rb", csr_rdata, 32'hA5);

    // Unknown address and no-op funct3
    op(1, 3'b010, 12'h7C0, 32'h0, 5'd0);
    chk("unknown_rdata", csr_rdata, 32'h0);
    chk("unknown_ill", {31'b0, csr_illegal}, 32'h1);
    step();
    chk("ill_one_cycle", {31'b0, csr_illegal}, 32'h0);
    op(1, 3'b100, 12'h7C0, 32'hFFFF, 5'd7);
    chk("noop_ill", {31'b0, csr_illegal}, 32'h0);

    // Asynchronous reset mid-cycle while an operation is presented
    csr_we = 1; csr_rd = 1; funct3 = 3'b001; csr_addr = 12'h51E; rs1_data = 32'hDEAD;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("async_tohost", tohost, 32'h0);
    chk("async_rdata", csr_rdata, 32'h0);
    chk("async_ill", {31'b0, csr_illegal}, 32'h0);
    idle();
    #2;
    rst_n = 1;
    repeat (5) step();
    op(1, 3'b010, 12'hC00, 32'hFFFF, 5'd0);
`ifdef CSR_COUNTERS_EN
    chk("cycle_after5", csr_rdata, 32'd5);
    chk("cycle_ro_read_ok", {31'b0, csr_illegal}, 32'h0);
`else
    chk("cycle_absent_rd", csr_rdata, 32'h0);
    chk("cycle_absent_ill", {31'b0, csr_illegal}, 32'h1);
`endif
    op(1, 3'b001, 12'hC00, 32'h5555, 5'd1);
    chk("ro_write_ill", {31'b0, csr_illegal}, 32'h1);

    // Stall holds the write; commit on the release edge
    csr_we = 1; csr_rd = 1; funct3 = 3'b001; csr_addr = 12'h51E; rs1_data = 32'hCAFE;
    inst_retire = 1; stall = 1;
    repeat (3) begin
      step();
      chk("stall_hold", tohost, 32'h0);
    end
    stall = 0;
    step();
    chk("stall_commit", tohost, 32'hCAFE);
    idle();
    op(1, 3'b010, 12'hC02, 32'h0, 5'd0);

`ifdef CSR_COUNTERS_EN
    @(negedge clk);
    force dut.instret_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_cnt;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    inst_retire = 1;
    step();
    idle();
    op(1, 3'b010, 12'hC02, 32'h0, 5'd0);
    chk("wrap_lo", csr_rdata, 32'h0);
    op(1, 3'b010, 12'hC82, 32'h0, 5'd0);
    chk("wrap_hi", csr_rdata, 32'h0);
`else
    op(1, 3'b010, 12'hC02, 32'h0, 5'd0);
    chk("instret_absent_rd", csr_rdata, 32'h0);
    chk("instret_absent_ill", {31'b0, csr_illegal}, 32'h1);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      csr_we      = ($urandom_range(0, 9) < 6);
      csr_rd      = $urandom_range(0, 1);
      funct3      = 3'($urandom_range(0, 7));
      csr_addr    = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 7)];
      rs1_data    = $urandom;
      zimm        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      stall       = ($urandom_range(0, 3) == 0);
      inst_retire = $urandom_range(0, 1);
      step();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Control and status register unit for the RISC-V core. It executes the Zicsr operation that the instruction decoder flags with its `csr_we`/`csr_rd` controls. It holds the `tohost` and `mscratch` registers and the optional 64-bit `cycle`/`instret` counters, and returns the old CSR value, registered, to the writeback mux select `mem_to_reg = 2'b01`.

## Interface
Parameters:
- `XLEN`, 32: data width; all CSRs are XLEN wide, and counters are 2×XLEN.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `stall` input 1: pipeline stall; blocks CSR commit, read capture and instret increment.
- `csr_we` input 1: a CSR instruction is in this stage (decoder `csr_we`).
- `csr_rd` input 1: rd ≠ x0, so the old value must be returned (decoder `csr_rd`).
- `funct3` input 3: inst[14:12], the operation select.
- `csr_addr` input 12: inst[31:20].
- `rs1_data` input XLEN: register source operand.
- `zimm` input 5: inst[19:15], also used as the rs1 index for the zero test.
- `inst_retire` input 1: one instruction retires this cycle.
- `csr_rdata` output XLEN: registered old CSR value.
- `csr_illegal` output 1: registered one-cycle pulse for an access to an unknown address or a write to a read-only address.
- `tohost` output XLEN: current `tohost` register value, driven directly from the flop.

## Operation
- An operation is active when `csr_we && !stall`.
- Operand select:
  - `src = funct3[2] ? {zero-extend zimm} : rs1_data`.
  - `src_zero = (zimm == 0)`. This applies to both forms because inst[19:15] is the rs1 index.
- `funct3` decode:
  - 001 RW: `new = src`.
  - 010 RS: `new = old | src`.
  - 011 RC: `new = old & ~src`.
  - 101/110/111: the immediate forms of RW/RS/RC.
  - 000/100: no-op. No write, no read capture, no illegal flag.
- Write suppression: RS/RC/RSI/RCI with `src_zero` perform no write, so a read-only CSR may be read with them without error. RW/RWI always write.
- Address map:
  - 0x51E `tohost`: RW.
  - 0x340 `mscratch`: RW.
  - 0xC00/0xC80 `cycle`/`cycleh`: RO.
  - 0xC02/0xC82 `instret`/`instreth`: RO.
  - Any other address: reads 0, writes are dropped, `csr_illegal` pulses.
- Writes to RO addresses are dropped and `csr_illegal` pulses.
- Read capture: if the operation is active and `csr_rd = 1`, `csr_rdata <= old` at the edge. Otherwise `csr_rdata` holds its value.
- Counters:
  - `cycle` increments every clock, including stall cycles.
  - `instret` increments when `inst_retire && !stall`.
  - Both are 64-bit and wrap from 2^64−1 to 0.

## Timing
- Reset (`rst_n` low): `tohost`, `mscratch`, `cycle`, `instret`, `csr_rdata` = 0 and `csr_illegal` = 0, applied immediately and asynchronously. Counting resumes on the first rising edge after deassertion.
- Write latency: a new CSR value is visible on `tohost` and to the next reader one cycle after the active edge.
- Read latency: `csr_rdata` is valid in cycle N+1 for an operation issued in cycle N.
- `old` is the pre-edge value. Back-to-back operations on one address in N and N+1 therefore see N's write in N+1.
- Counter reads return the pre-increment value of cycle N. Reading `cycleh` after `cycle` is not atomic; software handles the carry.
- `csr_illegal` is high for exactly the cycle after the offending active edge.
- A stall during an operation holds everything except `cycle`. The operation commits on the first non-stalled edge.

## Configuration
- `CSR_COUNTERS_EN` defined: `cycle`/`instret` logic is present as described above.
- `CSR_COUNTERS_EN` undefined: no counter flops exist. 0xC00/0xC80/0xC02/0xC82 are treated as unknown addresses: they read 0 and pulse `csr_illegal`. `inst_retire` is ignored.

## Test plan
- Reset: hold `rst_n` low mid-operation → all outputs 0 with no clock edge. Release, then run 5 clocks, then read `cycle` → 5 (± the read-issue offset checked exactly by the bench).
- RW/RS/RC: `csrrw tohost`, src=0x1234 → `tohost` = 0x1234 next cycle. Then `csrrs` src=0x0F00, rd≠0 → `csr_rdata` = 0x1234 and `tohost` = 0x1F34. Then `csrrci` zimm=4 → `tohost` = 0x1F30.
- Read-only and zero-source rules: `csrrs cycle` with zimm=0 → read, no illegal. `csrrw cycle` → `csr_illegal` for one cycle and `cycle` unchanged. Address 0x7C0 → `csr_rdata` = 0 and illegal.
- `csr_rd = 0`: `csrrw mscratch`=0xA5 with `csr_rd` low → `csr_rdata` unchanged and `mscratch` = 0xA5.
- Stall: stall 3 cycles with `csr_we` and `inst_retire` high → no commit and `instret` unchanged. `cycle` advances 3. Commit occurs on the release edge.
- Wrap (counters enabled): force `instret` to 2^64−1, retire once → `instret` = 0 and `instreth` = 0. With the macro off → 0xC02 reads 0 and `csr_illegal` pulses.
